// File: rtl/sobel_stream_engine_if.sv
// rtl/sobel_stream_engine_if.sv - pixel input/output stream bundle for the Sobel engine
interface sobel_stream_engine_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] DATA_I;
  logic              DATA_EN_I;
  logic [DATA_W-1:0] PIXEL_O;
  logic              PIXEL_EN_O;

  modport master (
    output DATA_I,
    output DATA_EN_I,
    input  PIXEL_O,
    input  PIXEL_EN_O
  );

  modport slave (
    input  DATA_I,
    input  DATA_EN_I,
    output PIXEL_O,
    output PIXEL_EN_O
  );
endinterface

// File: rtl/sobel_stream_engine.sv
// rtl/sobel_stream_engine.sv - raster-order 3x3 Sobel engine with line buffers, modes and frame sequencing
module sobel_stream_engine #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 540,
  parameter int IMG_H  = 540
) (
  input  logic                CLK,
  input  logic                RST,
  sobel_stream_engine_if.slave STREAM,
  input  logic                CORE_RUN_I,
  input  logic [1:0]          MODE_I,
  input  logic [DATA_W-1:0]   THRESH_I,
  output logic                BUSY_O,
  output logic                CORE_DONE_O
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DATA_W + 3;
  localparam logic [DATA_W-1:0] MAXV     = '1;
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH1, S_FLUSH2, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_thresh;
  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];
  logic [DATA_W-1:0] r_win [3][3];
  logic              r_win_v;
  logic [DATA_W-1:0] r_pix;
  logic              r_pix_en;

  logic              w_acc, w_last, w_qual;
  logic signed [GW-1:0] w_gx, w_gy;
  logic [GW-1:0]     w_agx, w_agy, w_mag;
  logic [DATA_W-1:0] w_res;

  assign w_acc  = (r_state == S_RUN) && STREAM.DATA_EN_I;
  assign w_last = w_acc && (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_qual = w_acc && (r_row >= RW'(2)) && (r_col >= CW'(2));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    BUSY_O      = 1'b1;
    CORE_DONE_O = 1'b0;
    case (r_state)
      S_IDLE: begin
        BUSY_O = 1'b0;
        if (CORE_RUN_I) w_next = S_RUN;
      end
      S_RUN:    if (w_last) w_next = S_FLUSH1;
      S_FLUSH1: w_next = S_FLUSH2;
      S_FLUSH2: w_next = S_DONE;
      S_DONE: begin
        CORE_DONE_O = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_row    <= '0;
      r_col    <= '0;
      r_mode   <= '0;
      r_thresh <= '0;
    end else if (r_state == S_IDLE && CORE_RUN_I) begin
      r_row    <= '0;
      r_col    <= '0;
      r_mode   <= MODE_I;
      r_thresh <= THRESH_I;
    end else if (w_acc) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Each accepted pixel pushes one column (two rows up, one row up, current) into the window.
  always_ff @(posedge CLK) begin
    if (w_acc) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= STREAM.DATA_I;
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= r_lb0[r_col];
      r_win[1][2] <= r_lb1[r_col];
      r_win[2][2] <= STREAM.DATA_I;
    end
  end

  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] v);
    return {3'b000, v};
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic [GW-1:0] v);
    return (v > {3'b000, MAXV}) ? MAXV : v[DATA_W-1:0];
  endfunction

  always_comb begin
    w_gx  = (ext(r_win[0][2]) + (ext(r_win[1][2]) <<< 1) + ext(r_win[2][2]))
          - (ext(r_win[0][0]) + (ext(r_win[1][0]) <<< 1) + ext(r_win[2][0]));
    w_gy  = (ext(r_win[2][0]) + (ext(r_win[2][1]) <<< 1) + ext(r_win[2][2]))
          - (ext(r_win[0][0]) + (ext(r_win[0][1]) <<< 1) + ext(r_win[0][2]));
    w_agx = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    w_agy = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    w_mag = w_agx + w_agy;
    case (r_mode)
      2'd0:    w_res = sat(w_mag);
      2'd1:    w_res = (w_mag >= {3'b000, r_thresh}) ? MAXV : '0;
      2'd2:    w_res = sat(w_agx);
      default: w_res = r_win[1][1];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_win_v  <= 1'b0;
      r_pix_en <= 1'b0;
      r_pix    <= '0;
    end else begin
      r_win_v  <= w_qual;
      r_pix_en <= r_win_v;
      if (r_win_v) r_pix <= w_res;
    end
  end

  assign STREAM.PIXEL_O    = r_pix;
  assign STREAM.PIXEL_EN_O = r_pix_en;
endmodule
